meas_sequencer: RTL

MEAS_SEQUENCER -- requirements
Module: meas_sequencer

---
 rtl/meas_sequencer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/meas_sequencer.sv
// meas_sequencer: round-robin measurement sequencer over four sources
// (sensor, TDC, RO, RO2). Selects a source, waits for it to settle, samples
// it and presents the result with a valid/ready handshake.
// Optional build macro MEAS_SEQ_AVG_EN: sample each source over 4 cycles
// and present the average instead of a single sample.
module meas_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run_i,
  input  logic [3:0] ch_mask_i,
  input  logic [7:0] meas_i,
  output logic [1:0] sel_o,
  output logic [7:0] res_data_o,
  output logic [1:0] res_ch_o,
  output logic       res_valid_o,
  input  logic       res_ready_i,
  output logic       busy_o
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, PRESENT} state_e;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] res_ch_q, res_ch_d;
  logic [7:0] res_data_q, res_data_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] ptr_next;

`ifdef MEAS_SEQ_AVG_EN
  localparam logic [3:0] SAMPLE_LOAD = 4'd3;
  logic [9:0] acc_q, acc_d, acc_sum;
  assign acc_sum = acc_q + {2'b00, meas_i};
`endif

  // First enabled channel at or above start, wrapping 3->0.
  function automatic logic [1:0] first_enabled(input logic [3:0] mask,
                                               input logic [1:0] start);
    logic [1:0] idx;
    logic [1:0] pick;
    logic       found;
    pick  = start;
    found = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = start + 2'(i);
      if (!found && mask[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign ptr_next = res_ch_q + 2'd1;

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      sel_q      <= '0;
      res_ch_q   <= '0;
      res_data_q <= '0;
      cnt_q      <= '0;
`ifdef MEAS_SEQ_AVG_EN
      acc_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      sel_q      <= sel_d;
      res_ch_q   <= res_ch_d;
      res_data_q <= res_data_d;
      cnt_q      <= cnt_d;
`ifdef MEAS_SEQ_AVG_EN
      acc_q      <= acc_d;
`endif
    end
  end

  // Next-state logic: channel selection, settle/sample counting, handshake.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    sel_d      = sel_q;
    res_ch_d   = res_ch_q;
    res_data_d = res_data_q;
    cnt_d      = cnt_q;
`ifdef MEAS_SEQ_AVG_EN
    acc_d      = acc_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (run_i && (ch_mask_i != '0)) begin
          state_d = SETTLE;
          sel_d   = first_enabled(ch_mask_i, ptr_q);
          cnt_d   = SETTLE_LOAD;
        end
      end
      SETTLE: begin
        if (!run_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = SAMPLE;
`ifdef MEAS_SEQ_AVG_EN
          cnt_d   = SAMPLE_LOAD;
          acc_d   = '0;
`endif
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      SAMPLE: begin
`ifdef MEAS_SEQ_AVG_EN
        acc_d = acc_sum;
        if (cnt_q == '0) begin
          res_data_d = acc_sum[9:2];
          res_ch_d   = sel_q;
          state_d    = PRESENT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
`else
        res_data_d = meas_i;
        res_ch_d   = sel_q;
        state_d    = PRESENT;
`endif
      end
      PRESENT: begin
        if (res_ready_i) begin
          ptr_d = ptr_next;
          // Next channel is chosen directly from the advanced pointer so a
          // running sequence goes straight back to SETTLE without an IDLE gap.
          if (run_i && (ch_mask_i != '0)) begin
            state_d = SETTLE;
            sel_d   = first_enabled(ch_mask_i, ptr_next);
            cnt_d   = SETTLE_LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sel_o       = sel_q;
  assign res_data_o  = res_data_q;
  assign res_ch_o    = res_ch_q;
  assign res_valid_o = (state_q == PRESENT);
  assign busy_o      = (state_q != IDLE);

endmodule
